// File: rtl/key_debounce_pulse.sv
// key_debounce_pulse: per-key pushbutton conditioning in the clk_40M domain.
// The divided clk_debounce wave is only edge-detected and used as a sample
// enable. Each key gets a 2-flop synchronizer, a DB_LEN-sample debounce shift
// register, press/release pulses and an auto-repeat FSM counting ticks.
module key_debounce_pulse #(
  parameter int N_KEY       = 4,
  parameter int DB_LEN      = 4,
  parameter int REPEAT_DLY  = 77,
  parameter int REPEAT_RATE = 15
) (
  input  logic             clk_40M,
  input  logic             rst,
  input  logic             clk_debounce,
  input  logic [N_KEY-1:0] key_in,
  output logic [N_KEY-1:0] key_level,
  output logic [N_KEY-1:0] key_press,
  output logic [N_KEY-1:0] key_release,
  output logic [N_KEY-1:0] key_repeat
);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_HOLD_DLY  = 2'd1;
  localparam logic [1:0] ST_REPEATING = 2'd2;

  localparam logic [7:0] DLY_CNT  = 8'(REPEAT_DLY);
  localparam logic [7:0] RATE_CNT = 8'(REPEAT_RATE);

  logic [N_KEY-1:0]             sync1_q, sync1_d;
  logic [N_KEY-1:0]             sync2_q, sync2_d;
  logic                         div_q, div_d;
  logic                         tick;
  logic [N_KEY-1:0][DB_LEN-1:0] shift_q, shift_d;
  logic [N_KEY-1:0]             level_q, level_d;
  logic [N_KEY-1:0]             prev_q, prev_d;
  logic [N_KEY-1:0]             press_q, press_d;
  logic [N_KEY-1:0]             release_q, release_d;
  logic [N_KEY-1:0]             repeat_q, repeat_d;
  logic [N_KEY-1:0][1:0]        state_q, state_d;
  logic [N_KEY-1:0][7:0]        cnt_q, cnt_d;
  logic [N_KEY-1:0][7:0]        cnt_inc;

  // One clk_40M-wide tick per rising edge of the divided wave.
  assign tick = clk_debounce & ~div_q;

  // Synchronizer chain and divider history next-state.
  always_comb begin
    sync1_d = key_in;
    sync2_d = sync1_q;
    div_d   = clk_debounce;
  end

  // Shift a new sample in on each tick; the level only moves on a unanimous window.
  always_comb begin
    shift_d = shift_q;
    level_d = level_q;
    for (int k = 0; k < N_KEY; k++) begin
      if (tick) begin
        shift_d[k] = {shift_q[k][DB_LEN-2:0], sync2_q[k]};
        if (&shift_d[k]) begin
          level_d[k] = 1'b1;
        end else if (~|shift_d[k]) begin
          level_d[k] = 1'b0;
        end
      end
    end
  end

  // Press/release pulses fire the cycle after the registered level changes.
  always_comb begin
    prev_d    = level_q;
    press_d   = level_q & ~prev_q;
    release_d = ~level_q & prev_q;
  end

  // Auto-repeat FSM; it watches the next level so a release on an expiry tick suppresses the repeat.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    repeat_d = '0;
    cnt_inc  = '0;
    for (int k = 0; k < N_KEY; k++) begin
      cnt_inc[k] = cnt_q[k] + 8'd1;
      if (!level_d[k]) begin
        state_d[k] = ST_IDLE;
        cnt_d[k]   = '0;
      end else begin
        case (state_q[k])
          ST_IDLE: begin
            state_d[k] = ST_HOLD_DLY;
            cnt_d[k]   = '0;
          end
          ST_HOLD_DLY: begin
            if (tick) begin
              if (cnt_inc[k] == DLY_CNT) begin
                repeat_d[k] = 1'b1;
                state_d[k]  = ST_REPEATING;
                cnt_d[k]    = '0;
              end else begin
                cnt_d[k] = cnt_inc[k];
              end
            end
          end
          ST_REPEATING: begin
            if (tick) begin
              if (cnt_inc[k] == RATE_CNT) begin
                repeat_d[k] = 1'b1;
                cnt_d[k]    = '0;
              end else begin
                cnt_d[k] = cnt_inc[k];
              end
            end
          end
          default: begin
            state_d[k] = ST_IDLE;
            cnt_d[k]   = '0;
          end
        endcase
      end
    end
  end

  // State registers; everything clears asynchronously while rst is low.
  always_ff @(posedge clk_40M or negedge rst) begin
    if (!rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      div_q     <= 1'b0;
      shift_q   <= '0;
      level_q   <= '0;
      prev_q    <= '0;
      press_q   <= '0;
      release_q <= '0;
      repeat_q  <= '0;
      state_q   <= {N_KEY{ST_IDLE}};
      cnt_q     <= '0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      div_q     <= div_d;
      shift_q   <= shift_d;
      level_q   <= level_d;
      prev_q    <= prev_d;
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
    end
  end

  assign key_level   = level_q;
  assign key_press   = press_q;
  assign key_release = release_q;
  assign key_repeat  = repeat_q;

endmodule

// File: tb/tb_key_debounce_pulse.sv
// Testbench for key_debounce_pulse with DB_LEN=4, REPEAT_DLY=3, REPEAT_RATE=2.
// Each table row is one 16-cycle clk_debounce period: keys applied at its
// start, expected level at its end and which pulses appear during it.
module tb_key_debounce_pulse;

  logic       clk_40M = 1'b0;
  logic       rst = 1'b1;
  logic       clk_debounce = 1'b0;
  logic [3:0] key_in = 4'b0000;
  logic [3:0] key_level, key_press, key_release, key_repeat;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [3:0] keys;
    bit         run;
    bit         rst_before;
    logic [3:0] lvl;
    logic [3:0] prs;
    logic [3:0] rel;
    logic [3:0] rpt;
  } vec_t;

  vec_t tbl[$];

  always #5 clk_40M = ~clk_40M;

  key_debounce_pulse #(
    .N_KEY      (4),
    .DB_LEN     (4),
    .REPEAT_DLY (3),
    .REPEAT_RATE(2)
  ) dut (
    .clk_40M     (clk_40M),
    .rst         (rst),
    .clk_debounce(clk_debounce),
    .key_in      (key_in),
    .key_level   (key_level),
    .key_press   (key_press),
    .key_release (key_release),
    .key_repeat  (key_repeat)
  );

  task automatic add(input logic [3:0] keys, input bit run, input bit rb,
                     input logic [3:0] lvl, input logic [3:0] prs,
                     input logic [3:0] rel, input logic [3:0] rpt);
    vec_t v;
    v.keys = keys; v.run = run; v.rst_before = rb;
    v.lvl = lvl; v.prs = prs; v.rel = rel; v.rpt = rpt;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %b, expected %b", name, idx, act, exp);
    end
  endtask

  task automatic check_n(input string name, input int idx, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  // One divider period. The tick edge is the posedge after sample i=3, so a
  // level change or repeat is visible only at sample i=4 and press/release
  // only at sample i=5; anything else counts as a timing error.
  task automatic step(input logic [3:0] keys, input bit run,
                      output logic [3:0] lvl, output logic [3:0] prs,
                      output logic [3:0] rel, output logic [3:0] rpt,
                      output int terr);
    logic [3:0] lvl0;
    logic [3:0] lvl4;
    lvl0 = key_level;
    lvl4 = key_level;
    prs = '0; rel = '0; rpt = '0; terr = 0;
    key_in = keys;
    for (int i = 0; i < 16; i++) begin
      if (run) clk_debounce = (i >= 4 && i < 12);
      @(posedge clk_40M);
      @(negedge clk_40M);
      prs |= key_press;
      rel |= key_release;
      rpt |= key_repeat;
      if (i != 5 && (key_press | key_release) != 4'b0000) terr++;
      if (i != 4 && key_repeat != 4'b0000) terr++;
      if (i < 4) begin
        if (key_level !== lvl0) terr++;
      end else if (i == 4) begin
        lvl4 = key_level;
      end else if (key_level !== lvl4) begin
        terr++;
      end
    end
    lvl = key_level;
  endtask

  task automatic reset_midhold();
    rst = 1'b0;
    #1;
    check("rst_now_level",   -1, key_level,   4'b0000);
    check("rst_now_press",   -1, key_press,   4'b0000);
    check("rst_now_release", -1, key_release, 4'b0000);
    check("rst_now_repeat",  -1, key_repeat,  4'b0000);
    repeat (3) @(negedge clk_40M);
    check("rst_hold_level",  -1, key_level,   4'b0000);
    check("rst_hold_repeat", -1, key_repeat,  4'b0000);
    rst = 1'b1;
  endtask

  initial begin
    logic [3:0] lvl, prs, rel, rpt;
    int terr;

    // Key 0: clean press held 10 ticks, then released.
    add(4'b0001,1,0, 4'b0000,4'b0000,4'b0000,4'b0000);
    add(4'b0001,1,0, 4'b0000,4'b0000,4'b0000,4'b0000);
    add(4'b0001,1,0, 4'b0000,4'b0000,4'b0000,4'b0000);
    add(4'b0001,1,0, 4'b0001,4'b0001,4'b0000,4'b0000);
    add(4'b0001,1,0, 4'b0001,4'b0000,4'b0000,4'b0000);
    add(4'b0001,1,0, 4'b0001,4'b0000,4'b0000,4'b0000);
    add(4'b0001,1,0, 4'b0001,4'b0000,4'b0000,4'b0001);
    add(4'b0001,1,0, 4'b0001,4'b0000,4'b0000,4'b0000);
    add(4'b0001,1,0, 4'b0001,4'b0000,4'b0000,4'b0001);
    add(4'b0001,1,0, 4'b0001,4'b0000,4'b0000,4'b0000);
    add(4'b0000,1,0, 4'b0001,4'b0000,4'b0000,4'b0001);
    add(4'b0000,1,0, 4'b0001,4'b0000,4'b0000,4'b0000);
    add(4'b0000,1,0, 4'b0001,4'b0000,4'b0000,4'b0001);
    add(4'b0000,1,0, 4'b0000,4'b0000,4'b0001,4'b0000);
    // Key 2: bounce 1-0-1-0-1 then steady 1, then release.
    add(4'b0100,1,0, 4'b0000,4'b0000,4'b0000,4'b0000);
    add(4'b0000,1,0, 4'b0000,4'b0000,4'b0000,4'b0000);
    add(4'b0100,1,0, 4'b0000,4'b0000,4'b0000,4'b0000);
    add(4'b0000,1,0, 4'b0000,4'b0000,4'b0000,4'b0000);
    add(4'b0100,1,0, 4'b0000,4'b0000,4'b0000,4'b0000);
    add(4'b0100,1,0, 4'b0000,4'b0000,4'b0000,4'b0000);
    add(4'b0100,1,0, 4'b0000,4'b0000,4'b0000,4'b0000);
    add(4'b0100,1,0, 4'b0100,4'b0100,4'b0000,4'b0000);
    add(4'b0000,1,0, 4'b0100,4'b0000,4'b0000,4'b0000);
    add(4'b0000,1,0, 4'b0100,4'b0000,4'b0000,4'b0000);
    add(4'b0000,1,0, 4'b0100,4'b0000,4'b0000,4'b0100);
    add(4'b0000,1,0, 4'b0000,4'b0000,4'b0100,4'b0000);
    // Key 1: held 12 ticks after the level rises; repeats at 3,5,7,9,11.
    add(4'b0010,1,0, 4'b0000,4'b0000,4'b0000,4'b0000);
    add(4'b0010,1,0, 4'b0000,4'b0000,4'b0000,4'b0000);
    add(4'b0010,1,0, 4'b0000,4'b0000,4'b0000,4'b0000);
    add(4'b0010,1,0, 4'b0010,4'b0010,4'b0000,4'b0000);
    for (int h = 1; h <= 12; h++)
      add(4'b0010,1,0, 4'b0010,4'b0000,4'b0000, (h % 2 == 1 && h >= 3) ? 4'b0010 : 4'b0000);
    add(4'b0000,1,0, 4'b0010,4'b0000,4'b0000,4'b0010);
    add(4'b0000,1,0, 4'b0010,4'b0000,4'b0000,4'b0000);
    add(4'b0000,1,0, 4'b0010,4'b0000,4'b0000,4'b0010);
    add(4'b0000,1,0, 4'b0000,4'b0000,4'b0010,4'b0000);
    // Key 1 again: held 11 ticks so the debounced fall lands on a repeat expiry.
    add(4'b0010,1,0, 4'b0000,4'b0000,4'b0000,4'b0000);
    add(4'b0010,1,0, 4'b0000,4'b0000,4'b0000,4'b0000);
    add(4'b0010,1,0, 4'b0000,4'b0000,4'b0000,4'b0000);
    add(4'b0010,1,0, 4'b0010,4'b0010,4'b0000,4'b0000);
    for (int h = 1; h <= 11; h++)
      add(4'b0010,1,0, 4'b0010,4'b0000,4'b0000, (h % 2 == 1 && h >= 3) ? 4'b0010 : 4'b0000);
    add(4'b0000,1,0, 4'b0010,4'b0000,4'b0000,4'b0000);
    add(4'b0000,1,0, 4'b0010,4'b0000,4'b0000,4'b0010);
    add(4'b0000,1,0, 4'b0010,4'b0000,4'b0000,4'b0000);
    add(4'b0000,1,0, 4'b0000,4'b0000,4'b0010,4'b0000);
    // Keys 0 and 3 together; key 3 released while key 0 stays held.
    add(4'b1001,1,0, 4'b0000,4'b0000,4'b0000,4'b0000);
    add(4'b1001,1,0, 4'b0000,4'b0000,4'b0000,4'b0000);
    add(4'b1001,1,0, 4'b0000,4'b0000,4'b0000,4'b0000);
    add(4'b1001,1,0, 4'b1001,4'b1001,4'b0000,4'b0000);
    add(4'b0001,1,0, 4'b1001,4'b0000,4'b0000,4'b0000);
    add(4'b0001,1,0, 4'b1001,4'b0000,4'b0000,4'b0000);
    add(4'b0001,1,0, 4'b1001,4'b0000,4'b0000,4'b1001);
    add(4'b0001,1,0, 4'b0001,4'b0000,4'b1000,4'b0000);
    add(4'b0001,1,0, 4'b0001,4'b0000,4'b0000,4'b0001);
    // Reset while key 0 is REPEATING, key still held afterwards.
    add(4'b0001,1,1, 4'b0000,4'b0000,4'b0000,4'b0000);
    add(4'b0001,1,0, 4'b0000,4'b0000,4'b0000,4'b0000);
    add(4'b0001,1,0, 4'b0000,4'b0000,4'b0000,4'b0000);
    add(4'b0001,1,0, 4'b0001,4'b0001,4'b0000,4'b0000);
    add(4'b0001,1,0, 4'b0001,4'b0000,4'b0000,4'b0000);
    add(4'b0001,1,0, 4'b0001,4'b0000,4'b0000,4'b0000);
    // Stalled divider: key released but nothing moves; counter resumes after.
    add(4'b0000,0,0, 4'b0001,4'b0000,4'b0000,4'b0000);
    add(4'b0000,0,0, 4'b0001,4'b0000,4'b0000,4'b0000);
    add(4'b0000,0,0, 4'b0001,4'b0000,4'b0000,4'b0000);
    add(4'b0000,1,0, 4'b0001,4'b0000,4'b0000,4'b0001);
    add(4'b0000,1,0, 4'b0001,4'b0000,4'b0000,4'b0000);
    add(4'b0000,1,0, 4'b0001,4'b0000,4'b0000,4'b0001);
    add(4'b0000,1,0, 4'b0000,4'b0000,4'b0001,4'b0000);

    // Power-on reset.
    #2 rst = 1'b0;
    repeat (3) @(posedge clk_40M);
    @(negedge clk_40M);
    check("por_level",   0, key_level,   4'b0000);
    check("por_press",   0, key_press,   4'b0000);
    check("por_release", 0, key_release, 4'b0000);
    check("por_repeat",  0, key_repeat,  4'b0000);
    rst = 1'b1;
    @(negedge clk_40M);

    foreach (tbl[i]) begin
      if (tbl[i].rst_before) reset_midhold();
      step(tbl[i].keys, tbl[i].run, lvl, prs, rel, rpt, terr);
      check("level",   i, lvl, tbl[i].lvl);
      check("press",   i, prs, tbl[i].prs);
      check("release", i, rel, tbl[i].rel);
      check("repeat",  i, rpt, tbl[i].rpt);
      check_n("timing", i, terr, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/key_debounce_pulse.md
Name: key_debounce_pulse

Overview:
- Consumes the divided `clk_debounce` square wave from the frequency divider and turns raw pushbutton inputs into clean signals for the control FSMs.
- Per key it produces:
  - a debounced level,
  - a single-cycle press pulse,
  - a single-cycle release pulse,
  - auto-repeat pulses while the key is held.
- Everything runs in the `clk_40M` domain. `clk_debounce` is never used as a clock; only its rising edge is used, as a sample enable.

Parameters:
- N_KEY, 4: number of independent pushbutton channels.
- DB_LEN, 4: consecutive equal debounce samples required to change the debounced level (2..8).
- REPEAT_DLY, 77: debounce ticks from press to first repeat pulse (1..255; about 0.5 s at the 6.55 ms tick).
- REPEAT_RATE, 15: debounce ticks between successive repeat pulses (1..255; about 100 ms).

Ports:
- clk_40M  input  1  system clock from the 40 MHz oscillator.
- rst  input  1  low active reset, asynchronous assert; all state clears while `rst`=0.
- clk_debounce  input  1  divided square wave from the frequency divider (period 2^18 clk_40M cycles).
- key_in  input  N_KEY  raw pushbuttons, active high, asynchronous to clk_40M.
- key_level  output  N_KEY  debounced key state.
- key_press  output  N_KEY  1-cycle pulse on debounced 0->1.
- key_release  output  N_KEY  1-cycle pulse on debounced 1->0.
- key_repeat  output  N_KEY  1-cycle pulse per auto-repeat interval while held.

Behaviour:
- Reset values: all outputs 0; synchronizers, shift registers, counters and `clk_debounce` history all 0; every FSM in IDLE.
- Synchronizer: each `key_in` bit passes through a 2-flop synchronizer.
- Tick generation:
  - `clk_debounce` is registered once.
  - tick = `clk_debounce` & ~registered copy, so it is exactly 1 clk_40M cycle per rising edge.
- Sampling: on tick, each key's DB_LEN-bit shift register shifts in the synchronized bit.
- Level update, on the same edge as the shift:
  - `key_level` <= 1 if the new shift value is all ones.
  - `key_level` <= 0 if it is all zeros.
  - Otherwise `key_level` holds.
- Latency: a clean edge on `key_in` reaches `key_level` on the DB_LEN-th tick after it clears the synchronizer.
- Bounce rejection: any glitch shorter than DB_LEN ticks never changes `key_level`.
- Press/release pulses:
  - `key_press` is high for exactly 1 cycle, on the edge after `key_level` rises.
  - `key_release` is high for exactly 1 cycle, on the edge after `key_level` falls.
- Per-key repeat FSM, with an 8-bit tick counter:
  - IDLE: counter=0. When `key_level` rises -> HOLD_DLY, counter=0.
  - HOLD_DLY: counter increments on each tick. When counter reaches REPEAT_DLY on a tick: pulse `key_repeat`, go to REPEATING, counter=0.
  - REPEATING: counter increments on each tick. When it reaches REPEAT_RATE: pulse `key_repeat`, counter=0. The counter wraps to 0 only by this compare, never by overflow.
  - From any state, `key_level`=0 -> IDLE, counter cleared, no `key_repeat` that cycle.
- Simultaneous events:
  - Release and repeat expiry in the same tick: release wins and `key_repeat` stays 0.
  - Keys are fully independent; any combination may pulse in the same cycle.
- Reset mid-hold:
  - Outputs drop to 0 immediately.
  - After `rst`=1, a still-held key needs DB_LEN fresh ticks, then produces `key_press` again.
- Stalled divider: if `clk_debounce` stops toggling, levels and counters freeze and no pulses are generated.

Test Plan:
- Bench settings: DB_LEN=4, REPEAT_DLY=3, REPEAT_RATE=2. The bench drives `clk_debounce` with a period of 16 clk_40M cycles.
- Clean press of `key_in`[0] held for 10 ticks -> `key_level`[0]=1 on the 4th tick. `key_press`[0] is high for 1 cycle on the following edge; no other bit toggles.
- Bounce 1-0-1-0-1 at tick spacing, then steady 1 -> `key_level` stays 0 until 4 consecutive 1 samples. Exactly one `key_press`.
- Hold `key_in`[1] for 12 ticks after `key_level` rises -> `key_repeat`[1] pulses at ticks 3, 5, 7, 9, 11. Release -> `key_release`[1] 1 cycle, FSM back to IDLE.
- Release timed so the debounced fall lands on a repeat-expiry tick -> `key_release` pulses and `key_repeat` stays 0.
- Keys 0 and 3 pressed on the same cycle -> `key_press`=4'b1001 in a single cycle; levels independent.
- Assert `rst`=0 mid-REPEATING, then deassert with the key held -> all outputs 0 during reset. `key_press` reappears 4 ticks after release of reset.
